ysyx_22050078_pcu: RTL and testbench
====================================

# ysyx_22050078_pcu

- Program-counter unit for the multi-cycle ysyx_22050078 core. Sits directly upstream of the instruction-fetch stage.
- Holds the architectural PC and issues one fetch request per instruction over a valid/ready handshake.
- Waits for the commit of that instruction, then selects and validates the next PC.
- Also maintains the retired-instruction counter and the halt/misalign status used by the simulation harness and difftest.

## Interface
Parameters:
- CPU_WIDTH, 64, datapath/PC width
- RESET_PC, 64'h8000_0000, PC value loaded by reset

Ports:
- clk  in  1  core clock, all state on rising edge
- rst  in  1  reset; one clock; synchronous, active-high
- o_pc  out  CPU_WIDTH  current PC, drives the fetch stage's i_pc
- o_dnpc  out  CPU_WIDTH  combinational next-PC candidate (see Operation), drives the fetch stage's i_dnpc
- o_fetch_valid  out  1  fetch request for o_pc
- i_fetch_ready  in  1  fetch stage accepts request
- i_commit  in  1  in-flight instruction retires this cycle
- i_jump_en  in  1  retiring instruction redirects (branch taken / jal / jalr)
- i_jump_target  in  CPU_WIDTH  redirect target
- i_trap_en  in  1  retiring instruction traps or returns (ecall/mret)
- i_trap_vec  in  CPU_WIDTH  trap/return target (mtvec/mepc)
- i_halt  in  1  retiring instruction is ebreak
- o_halted  out  1  core stopped, sticky until reset
- o_misalign  out  1  halted because next PC[1:0] != 0, sticky until reset
- o_inst_cnt  out  64  retired-instruction count

## Operation
- States:
  - IDLE: post-reset bubble.
  - REQ: fetch request outstanding.
  - WAIT: instruction in flight, awaiting commit.
  - HALT: terminal.
- Transitions:
  - IDLE -> REQ unconditionally.
  - REQ -> WAIT on o_fetch_valid && i_fetch_ready.
  - WAIT -> REQ on i_commit with no halt/misalign.
  - WAIT -> HALT on i_commit && (i_halt || selected next PC misaligned).
  - HALT stays in HALT until rst.
- o_fetch_valid = (state == REQ). The request must stay asserted, with o_pc stable, until accepted.
- Next-PC selection, priority high to low:
  - i_trap_en -> i_trap_vec
  - i_jump_en -> i_jump_target
  - otherwise o_pc + 4
- Arithmetic: o_pc + 4 is modulo 2^CPU_WIDTH. Wrap from 0xFFFF_FFFF_FFFF_FFFC to 0 is legal, not an error.
- o_dnpc is the selected next PC computed from the current inputs every cycle, in every state. Outside a commit it equals o_pc + 4 when both redirects are low.
- On commit in WAIT:
  - o_inst_cnt += 1, including the halting or misaligned instruction. The counter wraps modulo 2^64.
  - i_halt: PC unchanged, o_halted <= 1. i_halt overrides any redirect.
  - Selected PC[1:0] != 0: PC unchanged, o_halted <= 1, o_misalign <= 1.
  - Otherwise: PC <= selected PC.
- Ignored inputs:
  - i_commit outside WAIT is ignored; no count, no PC change.
  - i_fetch_ready outside REQ is ignored.
- In HALT, all of i_commit, i_fetch_ready, i_jump_*, i_trap_* and i_halt are ignored.

## Timing
- Reset values: o_pc = RESET_PC, state = IDLE, o_fetch_valid = 0, o_halted = 0, o_misalign = 0, o_inst_cnt = 0.
- Reset asserted in any state, including mid-handshake or in HALT, forces these values at the next edge. Any commit in that cycle is dropped.
- First request: rst deasserted at edge E0 -> IDLE during cycle E0..E1 -> o_fetch_valid high from E1.
- Handshake accepted at edge N -> WAIT from N. The earliest commit is sampled at edge N+1.
- A commit sampled at edge M updates o_pc and o_inst_cnt at M, and o_fetch_valid rises at M (REQ).
- Best-case throughput: 2 cycles per instruction (one REQ cycle, one WAIT cycle).
- All outputs except o_dnpc are registered. o_dnpc is combinational from o_pc and the commit-side inputs.

## Structure
- Shared defines file holds CPU_WIDTH, INST_WIDTH, RESET_PC and the 2-bit state encoding: IDLE=0, REQ=1, WAIT=2, HALT=3.
- One sub-module: ysyx_22050078_npc_sel, the purely combinational priority mux plus the misalign check (selected[1:0] != 0).
  - It feeds o_dnpc and the PC register.
- State register, PC register, counter and sticky flags live in the top.

## Test plan
- Reset/first fetch: hold rst 3 cycles, release -> o_pc = 0x80000000; o_fetch_valid low for 1 cycle, then high; o_inst_cnt = 0.
- Backpressure: i_fetch_ready low 4 cycles -> o_fetch_valid held high, o_pc stable at 0x80000000. Ready at cycle 5 -> WAIT. Commit with no redirect -> o_pc = 0x80000004, o_inst_cnt = 1.
- Redirect priority: commit with i_jump_en=1, target 0x80000100, and i_trap_en=1, vec 0x80000200 -> o_pc = 0x80000200. Same commit with only the jump -> o_pc = 0x80000100. o_dnpc matches in the commit cycle.
- Misalign: commit with jump target 0x80000102 -> o_halted = o_misalign = 1, o_pc unchanged, o_inst_cnt incremented, o_fetch_valid stays 0. Further commits are ignored.
- ebreak: commit with i_halt=1 and i_jump_en=1 -> o_halted = 1, o_misalign = 0, o_pc unchanged. Then rst for 1 cycle -> all reset values restored and fetching resumes at 0x80000000.
- Stray inputs and wrap:
  - i_commit pulsed in REQ -> no count or PC change.
  - With the PC preloaded via jump to 0xFFFFFFFFFFFFFFFC, a sequential commit -> o_pc = 0, no misalign.

Source files
------------

// File: rtl/ysyx_22050078_pcu_pkg.sv
// Shared constants and FSM encoding for the ysyx_22050078 program-counter unit.
package ysyx_22050078_pcu_pkg;

  localparam int unsigned CPU_WIDTH  = 64;
  localparam int unsigned INST_WIDTH = 32;
  localparam logic [63:0] RESET_PC   = 64'h8000_0000;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2,
    StHalt = 2'd3
  } pcu_state_e;

endpackage

// File: rtl/ysyx_22050078_npc_sel.sv
// Next-PC priority mux (trap > jump > sequential) with instruction-alignment check.
module ysyx_22050078_npc_sel #(
  parameter int unsigned CPU_WIDTH = ysyx_22050078_pcu_pkg::CPU_WIDTH
) (
  input  logic [CPU_WIDTH-1:0] i_pc,
  input  logic                 i_jump_en,
  input  logic [CPU_WIDTH-1:0] i_jump_target,
  input  logic                 i_trap_en,
  input  logic [CPU_WIDTH-1:0] i_trap_vec,
  output logic [CPU_WIDTH-1:0] o_npc,
  output logic                 o_misalign
);

  always_comb begin
    o_npc = i_pc + CPU_WIDTH'(4);
    if (i_trap_en) begin
      o_npc = i_trap_vec;
    end else if (i_jump_en) begin
      o_npc = i_jump_target;
    end
    o_misalign = (o_npc[1:0] != 2'b00);
  end

endmodule

// File: rtl/ysyx_22050078_pcu.sv
// Program-counter unit: issues one fetch per instruction, waits for commit, then advances
// the PC; also keeps the retired-instruction count and sticky halt/misalign status.
module ysyx_22050078_pcu #(
  parameter int unsigned           CPU_WIDTH = ysyx_22050078_pcu_pkg::CPU_WIDTH,
  parameter logic [CPU_WIDTH-1:0]  RESET_PC  = ysyx_22050078_pcu_pkg::RESET_PC
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [CPU_WIDTH-1:0] o_pc,
  output logic [CPU_WIDTH-1:0] o_dnpc,
  output logic                 o_fetch_valid,
  input  logic                 i_fetch_ready,
  input  logic                 i_commit,
  input  logic                 i_jump_en,
  input  logic [CPU_WIDTH-1:0] i_jump_target,
  input  logic                 i_trap_en,
  input  logic [CPU_WIDTH-1:0] i_trap_vec,
  input  logic                 i_halt,
  output logic                 o_halted,
  output logic                 o_misalign,
  output logic [63:0]          o_inst_cnt
);
  import ysyx_22050078_pcu_pkg::*;

  pcu_state_e           state_q;
  logic [CPU_WIDTH-1:0] pc_q;
  logic                 fetch_valid_q;
  logic                 halted_q;
  logic                 misalign_q;
  logic [63:0]          inst_cnt_q;

  logic [CPU_WIDTH-1:0] npc;
  logic                 npc_misalign;

  ysyx_22050078_npc_sel #(
    .CPU_WIDTH(CPU_WIDTH)
  ) u_npc_sel (
    .i_pc          (pc_q),
    .i_jump_en     (i_jump_en),
    .i_jump_target (i_jump_target),
    .i_trap_en     (i_trap_en),
    .i_trap_vec    (i_trap_vec),
    .o_npc         (npc),
    .o_misalign    (npc_misalign)
  );

  // fetch_valid_q is kept in lockstep with state_q == StReq so the request is registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      pc_q          <= RESET_PC;
      fetch_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      misalign_q    <= 1'b0;
      inst_cnt_q    <= 64'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_q       <= StReq;
          fetch_valid_q <= 1'b1;
        end
        StReq: begin
          if (i_fetch_ready) begin
            state_q       <= StWait;
            fetch_valid_q <= 1'b0;
          end
        end
        StWait: begin
          if (i_commit) begin
            inst_cnt_q <= inst_cnt_q + 64'd1;
            // ebreak wins over any redirect; a bad target halts without moving the PC.
            if (i_halt) begin
              state_q  <= StHalt;
              halted_q <= 1'b1;
            end else if (npc_misalign) begin
              state_q    <= StHalt;
              halted_q   <= 1'b1;
              misalign_q <= 1'b1;
            end else begin
              pc_q          <= npc;
              state_q       <= StReq;
              fetch_valid_q <= 1'b1;
            end
          end
        end
        StHalt: begin
          state_q <= StHalt;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign o_pc          = pc_q;
  assign o_dnpc        = npc;
  assign o_fetch_valid = fetch_valid_q;
  assign o_halted      = halted_q;
  assign o_misalign    = misalign_q;
  assign o_inst_cnt    = inst_cnt_q;

endmodule

// File: tb/tb_ysyx_22050078_pcu.sv
// Self-checking bench for ysyx_22050078_pcu: directed vector table plus randomized run
// against a behavioural instruction-level model.
module tb_ysyx_22050078_pcu;

  localparam logic [63:0] A = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] o_pc, o_dnpc, o_inst_cnt;
  logic        o_fetch_valid, o_halted, o_misalign;
  logic        i_fetch_ready, i_commit, i_jump_en, i_trap_en, i_halt;
  logic [63:0] i_jump_target, i_trap_vec;

  always #5 clk = ~clk;

  ysyx_22050078_pcu dut (
    .clk           (clk),
    .rst           (rst),
    .o_pc          (o_pc),
    .o_dnpc        (o_dnpc),
    .o_fetch_valid (o_fetch_valid),
    .i_fetch_ready (i_fetch_ready),
    .i_commit      (i_commit),
    .i_jump_en     (i_jump_en),
    .i_jump_target (i_jump_target),
    .i_trap_en     (i_trap_en),
    .i_trap_vec    (i_trap_vec),
    .i_halt        (i_halt),
    .o_halted      (o_halted),
    .o_misalign    (o_misalign),
    .o_inst_cnt    (o_inst_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: tracks where the current instruction is in its life.
  logic [63:0] m_pc  = A;
  logic [63:0] m_cnt = 64'd0;
  bit m_halted = 0, m_mis = 0, m_fv = 0, m_bubble = 1, m_inflight = 0;

  function automatic logic [63:0] ref_next();
    if (i_trap_en) return i_trap_vec;
    if (i_jump_en) return i_jump_target;
    return m_pc + 64'd4;
  endfunction

  task automatic model_edge();
    logic [63:0] nxt;
    nxt = ref_next();
    if (rst) begin
      m_pc = A; m_cnt = 64'd0; m_halted = 0; m_mis = 0;
      m_fv = 0; m_bubble = 1; m_inflight = 0;
    end else if (m_halted) begin
      // stopped until reset
    end else if (m_bubble) begin
      m_bubble = 0; m_fv = 1;
    end else if (m_fv) begin
      if (i_fetch_ready) begin m_fv = 0; m_inflight = 1; end
    end else if (m_inflight && i_commit) begin
      m_cnt = m_cnt + 64'd1;
      if (i_halt) m_halted = 1;
      else if (nxt[1:0] != 2'b00) begin m_halted = 1; m_mis = 1; end
      else begin m_pc = nxt; m_inflight = 0; m_fv = 1; end
    end
  endtask

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge: apply inputs, check the combinational next PC, advance one edge.
  task automatic step(input logic r, input logic rdy, input logic cm, input logic je,
                      input logic [63:0] jt, input logic te, input logic [63:0] tv,
                      input logic h);
    rst = r; i_fetch_ready = rdy; i_commit = cm; i_jump_en = je;
    i_jump_target = jt; i_trap_en = te; i_trap_vec = tv; i_halt = h;
    #1;
    if (!r) check64("dnpc", o_dnpc, ref_next());
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  typedef struct {
    logic r, rdy, cm, je; logic [63:0] jt; logic te; logic [63:0] tv; logic h;
    logic [63:0] pc; logic fv; logic [63:0] cnt; logic hl, mis;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic rdy, input logic cm, input logic je,
                     input logic [63:0] jt, input logic te, input logic [63:0] tv,
                     input logic h, input logic [63:0] pc, input logic fv,
                     input logic [63:0] cnt, input logic hl, input logic mis);
    vec_t v;
    v.r = r; v.rdy = rdy; v.cm = cm; v.je = je; v.jt = jt; v.te = te; v.tv = tv; v.h = h;
    v.pc = pc; v.fv = fv; v.cnt = cnt; v.hl = hl; v.mis = mis;
    vecs.push_back(v);
  endtask

  initial begin
    logic [63:0] jt, tv;
    rst = 1; i_fetch_ready = 0; i_commit = 0; i_jump_en = 0; i_trap_en = 0; i_halt = 0;
    i_jump_target = 0; i_trap_vec = 0;
    @(negedge clk);

    //   r rdy cm je jt               te tv         h | pc        fv cnt hl mis
    add(1, 0, 0, 0, 0,               0, 0,         0,  A,         0, 0, 0, 0);
    add(1, 0, 0, 0, 0,               0, 0,         0,  A,         0, 0, 0, 0);
    add(1, 0, 0, 0, 0,               0, 0,         0,  A,         0, 0, 0, 0);
    add(0, 1, 1, 0, 0,               0, 0,         0,  A,         1, 0, 0, 0); // stray in IDLE
    add(0, 0, 0, 0, 0,               0, 0,         0,  A,         1, 0, 0, 0);
    add(0, 0, 1, 0, 0,               0, 0,         0,  A,         1, 0, 0, 0); // stray in REQ
    add(0, 0, 0, 0, 0,               0, 0,         0,  A,         1, 0, 0, 0);
    add(0, 0, 0, 0, 0,               0, 0,         0,  A,         1, 0, 0, 0);
    add(0, 1, 0, 0, 0,               0, 0,         0,  A,         0, 0, 0, 0);
    add(0, 0, 1, 0, 0,               0, 0,         0,  A+4,       1, 1, 0, 0);
    add(0, 1, 0, 0, 0,               0, 0,         0,  A+4,       0, 1, 0, 0);
    add(0, 0, 1, 1, A+64'h100,       1, A+64'h200, 0,  A+64'h200, 1, 2, 0, 0);
    add(0, 1, 0, 0, 0,               0, 0,         0,  A+64'h200, 0, 2, 0, 0);
    add(0, 0, 1, 1, A+64'h100,       0, 0,         0,  A+64'h100, 1, 3, 0, 0);
    add(0, 1, 0, 0, 0,               0, 0,         0,  A+64'h100, 0, 3, 0, 0);
    add(0, 0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0,  64'hFFFF_FFFF_FFFF_FFFC, 1, 4, 0, 0);
    add(0, 1, 0, 0, 0,               0, 0,         0,  64'hFFFF_FFFF_FFFF_FFFC, 0, 4, 0, 0);
    add(0, 0, 1, 0, 0,               0, 0,         0,  64'd0,     1, 5, 0, 0); // wrap
    add(0, 1, 0, 0, 0,               0, 0,         0,  64'd0,     0, 5, 0, 0);
    add(0, 0, 1, 1, A+64'h102,       0, 0,         0,  64'd0,     0, 6, 1, 1); // misalign
    add(0, 1, 1, 1, A+64'h100,       0, 0,         1,  64'd0,     0, 6, 1, 1);
    add(1, 0, 0, 0, 0,               0, 0,         0,  A,         0, 0, 0, 0);
    add(0, 0, 0, 0, 0,               0, 0,         0,  A,         1, 0, 0, 0);
    add(0, 1, 0, 0, 0,               0, 0,         0,  A,         0, 0, 0, 0);
    add(0, 0, 1, 1, A+64'h100,       0, 0,         1,  A,         0, 1, 1, 0); // ebreak
    add(0, 1, 1, 0, 0,               0, 0,         0,  A,         0, 1, 1, 0);
    add(1, 0, 0, 0, 0,               0, 0,         0,  A,         0, 0, 0, 0);
    add(0, 0, 0, 0, 0,               0, 0,         0,  A,         1, 0, 0, 0);
    add(0, 1, 0, 0, 0,               0, 0,         0,  A,         0, 0, 0, 0);
    add(0, 0, 1, 0, 0,               0, 0,         0,  A+4,       1, 1, 0, 0);
    add(0, 1, 0, 0, 0,               0, 0,         0,  A+4,       0, 1, 0, 0);
    add(1, 0, 1, 1, A+64'h100,       0, 0,         0,  A,         0, 0, 0, 0); // commit dropped
    add(0, 0, 0, 0, 0,               0, 0,         0,  A,         1, 0, 0, 0);

    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].rdy, vecs[i].cm, vecs[i].je, vecs[i].jt,
           vecs[i].te, vecs[i].tv, vecs[i].h);
      check64($sformatf("vec%0d pc", i), o_pc, vecs[i].pc);
      check64($sformatf("vec%0d fetch_valid", i), 64'(o_fetch_valid), 64'(vecs[i].fv));
      check64($sformatf("vec%0d inst_cnt", i), o_inst_cnt, vecs[i].cnt);
      check64($sformatf("vec%0d halted", i), 64'(o_halted), 64'(vecs[i].hl));
      check64($sformatf("vec%0d misalign", i), 64'(o_misalign), 64'(vecs[i].mis));
    end

    for (int c = 0; c < 3000; c++) begin
      jt = {$urandom(), $urandom()};
      tv = {$urandom(), $urandom()};
      if ($urandom_range(15) != 0) jt[1:0] = 2'b00;
      if ($urandom_range(15) != 0) tv[1:0] = 2'b00;
      step(($urandom_range(99) == 0) || (m_halted && $urandom_range(7) == 0),
           1'($urandom_range(1)), 1'($urandom_range(1)),
           $urandom_range(3) == 0, jt, $urandom_range(7) == 0, tv,
           $urandom_range(31) == 0);
      check64("rnd pc", o_pc, m_pc);
      check64("rnd fetch_valid", 64'(o_fetch_valid), 64'(m_fv));
      check64("rnd inst_cnt", o_inst_cnt, m_cnt);
      check64("rnd halted", 64'(o_halted), 64'(m_halted));
      check64("rnd misalign", 64'(o_misalign), 64'(m_mis));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
